// File: rtl/bar_pkg.sv
// Shared types, widths and helpers for the scrolling-bar game datapath.
package bar_pkg;

    typedef enum logic [1:0] {IDLE, RUN, OVER} game_state_t;

    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned SCORE_MAX = 999;
    localparam int unsigned GAP_RESET = 240;

    function automatic logic [Y_W-1:0] clamp_gap(input logic [Y_W-1:0] r,
                                                 input logic [Y_W-1:0] lo,
                                                 input logic [Y_W-1:0] hi);
        logic [Y_W-1:0] res;
        res = r;
        if (r < lo) begin
            res = lo;
        end else if (r > hi) begin
            res = hi;
        end
        return res;
    endfunction

endpackage

// File: rtl/bar_scheduler_if.sv
// Bundle between the input/collision logic, the bar generators and the scheduler.
interface bar_scheduler_if
    import bar_pkg::*;
#(
    parameter int unsigned N_BARS = 3
) ();

    logic                     start_btn;
    logic                     collide;
    logic [N_BARS-1:0]        wrap_req;
    logic [X_W*N_BARS-1:0]    bar_x;
    logic                     game_run;
    logic                     step_en;
    logic [N_BARS-1:0]        wrap_gnt;
    logic [Y_W-1:0]           gap_y;
    logic [SCORE_W-1:0]       score;
    logic                     lose;

    modport master (
        output start_btn, collide, wrap_req, bar_x,
        input  game_run, step_en, wrap_gnt, gap_y, score, lose
    );

    modport slave (
        input  start_btn, collide, wrap_req, bar_x,
        output game_run, step_en, wrap_gnt, gap_y, score, lose
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest requesting index at or above the pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_q) + k) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                if (adv_i) begin
                    ptr_d = PW'((32'(idx) + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bar_scheduler.sv
// Game sequencer: IDLE/RUN/OVER FSM, scroll divider, gap LFSR, respawn arbitration and score.
module bar_scheduler
    import bar_pkg::*;
#(
    parameter int unsigned    N_BARS      = 3,
    parameter int unsigned    LVL1_PERIOD = 250000,
    parameter int unsigned    LVL2_PERIOD = 200000,
    parameter int unsigned    LVL_SCORE   = 3,
    parameter int unsigned    BIRD_X      = 160,
    parameter int unsigned    GAP_MIN     = 120,
    parameter int unsigned    GAP_MAX     = 360,
    parameter logic [Y_W-1:0] LFSR_SEED   = 9'h1A5
) (
    input logic            clk_25MHz,
    input logic            reset,
    bar_scheduler_if.slave bus_io
);

    localparam int unsigned DIV_W = 18;

    game_state_t           state_q, state_d;
    logic                  start_q;
    logic [DIV_W-1:0]      cnt_q, cnt_d, period_m1;
    logic [Y_W-1:0]        lfsr_q, lfsr_d, lfsr_nxt, gap_q, gap_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [SCORE_W:0]      pass_cnt, score_sum;
    logic [N_BARS-1:0]     gnt_q, gnt_d, arb_gnt;
    logic [X_W*N_BARS-1:0] prev_x_q;
    logic                  start_rise, active, step, fb;

    assign start_rise = bus_io.start_btn & ~start_q;
    // collide pre-empts every RUN-side event in its cycle
    assign active     = (state_q == RUN) & ~bus_io.collide;

    // A request already answered by gnt_q is still high this cycle; mask it.
    rr_arbiter #(
        .N(N_BARS)
    ) u_arb (
        .clk_i(clk_25MHz),
        .rst_i(reset),
        .req_i(bus_io.wrap_req & ~gnt_q),
        .adv_i(active),
        .gnt_o(arb_gnt)
    );

    always_comb begin
        pass_cnt = '0;
        for (int unsigned i = 0; i < N_BARS; i++) begin
            if (prev_x_q[X_W*i +: X_W] == X_W'(BIRD_X) &&
                bus_io.bar_x[X_W*i +: X_W] == X_W'(BIRD_X - 1)) begin
                pass_cnt = pass_cnt + (SCORE_W+1)'(1);
            end
        end
        score_sum = {1'b0, score_q} + pass_cnt;
        period_m1 = (score_q >= SCORE_W'(LVL_SCORE)) ? DIV_W'(LVL2_PERIOD - 1)
                                                     : DIV_W'(LVL1_PERIOD - 1);
        fb        = lfsr_q[8] ^ lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[2];
        lfsr_nxt  = {lfsr_q[7:0], fb};
        if (lfsr_nxt == '0) begin
            lfsr_nxt = LFSR_SEED;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        lfsr_d  = lfsr_q;
        gap_d   = gap_q;
        gnt_d   = '0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = RUN;
                    score_d = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (bus_io.collide) begin
                    state_d = OVER;
                end else begin
                    // >= also catches a period shrink that left the count past the end
                    step  = (cnt_q >= period_m1);
                    cnt_d = step ? '0 : cnt_q + DIV_W'(1);
                    gnt_d = arb_gnt;
                    if (|arb_gnt) begin
                        gap_d  = clamp_gap(lfsr_q, Y_W'(GAP_MIN), Y_W'(GAP_MAX));
                        lfsr_d = lfsr_nxt;
                    end
                    score_d = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                                     : score_sum[SCORE_W-1:0];
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            gap_q    <= Y_W'(GAP_RESET);
            score_q  <= '0;
            gnt_q    <= '0;
            prev_x_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus_io.start_btn;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            gap_q    <= gap_d;
            score_q  <= score_d;
            gnt_q    <= gnt_d;
            prev_x_q <= bus_io.bar_x;
        end
    end

    assign bus_io.game_run = (state_q == RUN);
    assign bus_io.lose     = (state_q == OVER);
    assign bus_io.step_en  = step;
    assign bus_io.wrap_gnt = gnt_q;
    assign bus_io.gap_y    = gap_q;
    assign bus_io.score    = score_q;

endmodule
